rpn_calculator: RTL

- Parametrised successor to the single-accumulator calculator chip: a stack-based (RPN) calculator of configurable data width and stack depth.
- Commands are issued by a rising edge on `enter`, which is synchronised and edge-detected internally.
- Adds more operations, carry/borrow reporting and sticky overflow/underflow error flags.
- Instantiated directly under the TinyTapeout wrapper: operands come from the switch inputs, the opcode and `enter` come from the bidirectional inputs, and `result` drives the display outputs.

---
 rtl/rpn_calculator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rpn_calculator.sv
// Stack-based (RPN) calculator with a synchronised, edge-detected command strobe.
// It supports PUSH, ADD, SUB, OR, AND, EQ, POP and CLEAR, with carry/borrow and sticky error flags.
module rpn_calculator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               num_in,
  input  logic [2:0]                     op_in,
  input  logic                           enter,
  output logic [WIDTH-1:0]               result,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           carry,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_OR    = 3'd3,
    OP_AND   = 3'd4,
    OP_EQ    = 3'd5,
    OP_POP   = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  logic             r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_carry, r_err_ovf, r_err_unf;

  logic             w_cmd_valid;
  op_e              w_op;
  logic [WIDTH-1:0] w_t, w_n, w_bin_res;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_stack_nxt [DEPTH];
  logic [DW-1:0]    w_depth_nxt;
  logic             w_carry_nxt, w_err_ovf_nxt, w_err_unf_nxt;

  assign w_cmd_valid = r_s2 & ~r_s3;
  assign w_op        = op_e'(op_in);

  // T and N are selected by comparing each slot index with the current depth.
  // Out-of-range positions, which only occur when depth < 2, select nothing and read as 0.
  always_comb begin
    w_t = '0;
    w_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == r_depth - DW'(1)) w_t = r_stack[i];
      if (DW'(i) == r_depth - DW'(2)) w_n = r_stack[i];
    end
  end

  assign w_sum  = {1'b0, w_n} + {1'b0, w_t};
  assign w_diff = {1'b0, w_n} - {1'b0, w_t};

  always_comb begin
    w_bin_res = '0;
    case (w_op)
      OP_ADD:  w_bin_res = w_sum[WIDTH-1:0];
      OP_SUB:  w_bin_res = w_diff[WIDTH-1:0];
      OP_OR:   w_bin_res = w_n | w_t;
      OP_AND:  w_bin_res = w_n & w_t;
      OP_EQ:   w_bin_res = (w_n == w_t) ? WIDTH'(1) : '0;
      default: w_bin_res = '0;
    endcase
  end

  // NOTE: every signal written here gets a default value first.
  // Without those defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    w_stack_nxt   = r_stack;
    w_depth_nxt   = r_depth;
    w_carry_nxt   = r_carry;
    w_err_ovf_nxt = r_err_ovf;
    w_err_unf_nxt = r_err_unf;
    if (w_cmd_valid) begin
      case (w_op)
        OP_PUSH: begin
          if (r_depth < DW'(DEPTH)) begin
            for (int i = 0; i < DEPTH; i++)
              if (DW'(i) == r_depth) w_stack_nxt[i] = num_in;
            w_depth_nxt = r_depth + DW'(1);
          end else begin
            w_err_ovf_nxt = 1'b1;
          end
        end
        OP_ADD, OP_SUB, OP_OR, OP_AND, OP_EQ: begin
          if (r_depth >= DW'(2)) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (DW'(i) == r_depth - DW'(2)) w_stack_nxt[i] = w_bin_res;
              if (DW'(i) == r_depth - DW'(1)) w_stack_nxt[i] = '0;
            end
            w_depth_nxt = r_depth - DW'(1);
            if (w_op == OP_ADD) w_carry_nxt = w_sum[WIDTH];
            if (w_op == OP_SUB) w_carry_nxt = w_diff[WIDTH];
          end else begin
            w_err_unf_nxt = 1'b1;
          end
        end
        OP_POP: begin
          if (r_depth >= DW'(1)) begin
            for (int i = 0; i < DEPTH; i++)
              if (DW'(i) == r_depth - DW'(1)) w_stack_nxt[i] = '0;
            w_depth_nxt = r_depth - DW'(1);
          end else begin
            w_err_unf_nxt = 1'b1;
          end
        end
        OP_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) w_stack_nxt[i] = '0;
          w_depth_nxt   = '0;
          w_carry_nxt   = 1'b0;
          w_err_ovf_nxt = 1'b0;
          w_err_unf_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the stack entries are reset along with the control state.
  // This keeps the vacated entries at 0, so the outputs are fully defined straight out of reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      r_depth   <= '0;
      r_carry   <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_s1      <= enter;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_stack   <= w_stack_nxt;
      r_depth   <= w_depth_nxt;
      r_carry   <= w_carry_nxt;
      r_err_ovf <= w_err_ovf_nxt;
      r_err_unf <= w_err_unf_nxt;
    end
  end

  assign result  = (r_depth != '0) ? w_t : '0;
  assign depth   = r_depth;
  assign carry   = r_carry;
  assign err_ovf = r_err_ovf;
  assign err_unf = r_err_unf;

endmodule
